// File: rtl/inst_cache.sv
// Direct-mapped, read-only instruction cache with one-word lines. Hits return
// one cycle after the request; misses fetch a single word through mem_ctrl.
module inst_cache #(
  parameter int ADDR_LEN   = 32,
  parameter int INST_LEN   = 32,
  parameter int INDEX_BITS = 7
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req,
  input  logic [ADDR_LEN-1:0] if_addr,
  input  logic                flush,
  output logic [INST_LEN-1:0] inst_o,
  output logic                inst_valid,
  output logic                busy,
  output logic                icache_needed,
  output logic [ADDR_LEN-1:0] icache_addr,
  input  logic                mem_busy,
  input  logic                inst_data_enable,
  input  logic [INST_LEN-1:0] inst_i
);

  localparam int LINES = 1 << INDEX_BITS;
  localparam int TAG_W = ADDR_LEN - INDEX_BITS - 2;
  localparam logic [ADDR_LEN-1:0] WORD_MASK = ~ADDR_LEN'(3);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_WAIT      = 2'd1,
    S_FILL      = 2'd2,
    S_FILL_DROP = 2'd3
  } state_t;

  state_t state, next_state;

  logic [LINES-1:0]    valid_q;
  logic [TAG_W-1:0]    tag_mem  [LINES];
  logic [INST_LEN-1:0] data_mem [LINES];
  logic [ADDR_LEN-1:0] req_addr;

  logic [INDEX_BITS-1:0] lk_idx, rq_idx;
  logic [TAG_W-1:0]      lk_tag, rq_tag;
  logic                  hit;

  // Per-cycle actions decoded by the FSM and consumed by the datapath registers.
  logic hit_fire, miss_latch, issue, fill_done, deliver;

  assign lk_idx = if_addr[INDEX_BITS+1:2];
  assign lk_tag = if_addr[ADDR_LEN-1:INDEX_BITS+2];
  assign rq_idx = req_addr[INDEX_BITS+1:2];
  assign rq_tag = req_addr[ADDR_LEN-1:INDEX_BITS+2];
  assign hit    = valid_q[lk_idx] && (tag_mem[lk_idx] == lk_tag);
  assign busy   = (state != S_IDLE);

  always_ff @(posedge clk) begin
    if (!rst) state <= S_IDLE;
    else      state <= next_state;
  end

  always_comb begin
    next_state = state;
    hit_fire   = 1'b0;
    miss_latch = 1'b0;
    issue      = 1'b0;
    fill_done  = 1'b0;
    deliver    = 1'b0;
    case (state)
      S_IDLE: begin
        if (if_req && !flush) begin
          if (hit) begin
            hit_fire = 1'b1;
          end else begin
            miss_latch = 1'b1;
            next_state = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (flush) begin
          next_state = S_IDLE;
        end else if (!mem_busy) begin
          issue      = 1'b1;
          next_state = S_FILL;
        end
      end
      S_FILL: begin
        // A flush landing on the completion edge still fills but is not delivered.
        if (inst_data_enable) begin
          fill_done  = 1'b1;
          deliver    = !flush;
          next_state = S_IDLE;
        end else if (flush) begin
          next_state = S_FILL_DROP;
        end
      end
      S_FILL_DROP: begin
        if (inst_data_enable) begin
          fill_done  = 1'b1;
          next_state = S_IDLE;
        end
      end
      default: next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      valid_q       <= '0;
      inst_o        <= '0;
      inst_valid    <= 1'b0;
      icache_needed <= 1'b0;
      icache_addr   <= '0;
      req_addr      <= '0;
    end else begin
      inst_valid <= hit_fire || deliver;
      if (hit_fire) inst_o <= data_mem[lk_idx];
      if (deliver)  inst_o <= inst_i;
      if (miss_latch) req_addr <= if_addr & WORD_MASK;
      if (issue) begin
        icache_needed <= 1'b1;
        icache_addr   <= req_addr;
      end
      if (fill_done) begin
        icache_needed   <= 1'b0;
        valid_q[rq_idx] <= 1'b1;
      end
    end
  end

  // Tag/data arrays carry no reset; valid_q alone decides whether a line is live.
  always_ff @(posedge clk) begin
    if (rst && fill_done) begin
      tag_mem[rq_idx]  <= rq_tag;
      data_mem[rq_idx] <= inst_i;
    end
  end

endmodule

// File: tb/tb_inst_cache.sv
// Directed bench for inst_cache: a vector table for hits, misses and conflicts,
// then hand sequences for mem_busy stalls, flush during fill and reset mid-fill.
module tb_inst_cache;

  logic        clk;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic        flush;
  logic [31:0] inst_o;
  logic        inst_valid;
  logic        busy;
  logic        icache_needed;
  logic [31:0] icache_addr;
  logic        mem_busy;
  logic        inst_data_enable;
  logic [31:0] inst_i;

  int n_cmp = 0;
  int n_err = 0;

  inst_cache dut (
    .clk              (clk),
    .rst              (rst),
    .if_req           (if_req),
    .if_addr          (if_addr),
    .flush            (flush),
    .inst_o           (inst_o),
    .inst_valid       (inst_valid),
    .busy             (busy),
    .icache_needed    (icache_needed),
    .icache_addr      (icache_addr),
    .mem_busy         (mem_busy),
    .inst_data_enable (inst_data_enable),
    .inst_i           (inst_i)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        req;
    logic [31:0] addr;
    logic        flush;
    logic        mb;
    logic        de;
    logic [31:0] din;
    logic        e_valid;
    logic [31:0] e_inst;
    logic        e_need;
    logic [31:0] e_iaddr;
    logic        e_busy;
  } vec_t;

  vec_t tbl [24];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Drive one cycle of inputs, then sample 1 ns after the rising edge.
  task automatic apply(input logic r, input logic rq, input logic [31:0] a,
                       input logic fl, input logic mb, input logic de,
                       input logic [31:0] d);
    rst = r; if_req = rq; if_addr = a; flush = fl;
    mem_busy = mb; inst_data_enable = de; inst_i = d;
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag, input logic v, input logic [31:0] inst,
                           input logic need, input logic [31:0] iaddr, input logic b);
    chk($sformatf("%s.inst_valid", tag), {31'd0, inst_valid}, {31'd0, v});
    chk($sformatf("%s.inst_o", tag), inst_o, inst);
    chk($sformatf("%s.icache_needed", tag), {31'd0, icache_needed}, {31'd0, need});
    chk($sformatf("%s.icache_addr", tag), icache_addr, iaddr);
    chk($sformatf("%s.busy", tag), {31'd0, busy}, {31'd0, b});
  endtask

  initial begin
    rst = 1'b0; if_req = 1'b0; if_addr = '0; flush = 1'b0;
    mem_busy = 1'b0; inst_data_enable = 1'b0; inst_i = '0;

    //           rst req addr          fl mb de din             v  inst          need iaddr         busy
    tbl[0]  = '{1'b0,1'b0,32'h0,      1'b0,1'b0,1'b0,32'h0,        1'b0,32'h0,        1'b0,32'h0,   1'b0};
    tbl[1]  = '{1'b1,1'b1,32'h0,      1'b0,1'b0,1'b0,32'h0,        1'b0,32'h0,        1'b0,32'h0,   1'b1};
    tbl[2]  = '{1'b1,1'b0,32'h0,      1'b0,1'b0,1'b0,32'h0,        1'b0,32'h0,        1'b1,32'h0,   1'b1};
    tbl[3]  = '{1'b1,1'b0,32'h0,      1'b0,1'b0,1'b0,32'h0,        1'b0,32'h0,        1'b1,32'h0,   1'b1};
    tbl[4]  = '{1'b1,1'b0,32'h0,      1'b0,1'b0,1'b1,32'h0000_0513,1'b1,32'h0000_0513,1'b0,32'h0,   1'b0};
    tbl[5]  = '{1'b1,1'b1,32'h0,      1'b0,1'b0,1'b0,32'h0,        1'b1,32'h0000_0513,1'b0,32'h0,   1'b0};
    tbl[6]  = '{1'b1,1'b1,32'h0,      1'b0,1'b0,1'b0,32'h0,        1'b1,32'h0000_0513,1'b0,32'h0,   1'b0};
    tbl[7]  = '{1'b1,1'b0,32'h0,      1'b0,1'b0,1'b0,32'h0,        1'b0,32'h0000_0513,1'b0,32'h0,   1'b0};
    tbl[8]  = '{1'b1,1'b1,32'h4,      1'b0,1'b0,1'b0,32'h0,        1'b0,32'h0000_0513,1'b0,32'h0,   1'b1};
    tbl[9]  = '{1'b1,1'b0,32'h0,      1'b0,1'b0,1'b0,32'h0,        1'b0,32'h0000_0513,1'b1,32'h4,   1'b1};
    tbl[10] = '{1'b1,1'b0,32'h0,      1'b0,1'b0,1'b1,32'hAAAA_AAAA,1'b1,32'hAAAA_AAAA,1'b0,32'h4,   1'b0};
    tbl[11] = '{1'b1,1'b1,32'h4,      1'b0,1'b0,1'b0,32'h0,        1'b1,32'hAAAA_AAAA,1'b0,32'h4,   1'b0};
    tbl[12] = '{1'b1,1'b1,32'h204,    1'b0,1'b0,1'b0,32'h0,        1'b0,32'hAAAA_AAAA,1'b0,32'h4,   1'b1};
    tbl[13] = '{1'b1,1'b0,32'h0,      1'b0,1'b0,1'b0,32'h0,        1'b0,32'hAAAA_AAAA,1'b1,32'h204, 1'b1};
    tbl[14] = '{1'b1,1'b0,32'h0,      1'b0,1'b0,1'b1,32'hBBBB_BBBB,1'b1,32'hBBBB_BBBB,1'b0,32'h204, 1'b0};
    tbl[15] = '{1'b1,1'b1,32'h204,    1'b0,1'b0,1'b0,32'h0,        1'b1,32'hBBBB_BBBB,1'b0,32'h204, 1'b0};
    tbl[16] = '{1'b1,1'b1,32'h4,      1'b0,1'b0,1'b0,32'h0,        1'b0,32'hBBBB_BBBB,1'b0,32'h204, 1'b1};
    tbl[17] = '{1'b1,1'b0,32'h0,      1'b0,1'b0,1'b0,32'h0,        1'b0,32'hBBBB_BBBB,1'b1,32'h4,   1'b1};
    tbl[18] = '{1'b1,1'b0,32'h0,      1'b0,1'b0,1'b1,32'hAAAA_AAAA,1'b1,32'hAAAA_AAAA,1'b0,32'h4,   1'b0};
    tbl[19] = '{1'b1,1'b1,32'h3,      1'b0,1'b0,1'b0,32'h0,        1'b1,32'h0000_0513,1'b0,32'h4,   1'b0};
    tbl[20] = '{1'b1,1'b1,32'h8,      1'b1,1'b0,1'b0,32'h0,        1'b0,32'h0000_0513,1'b0,32'h4,   1'b0};
    tbl[21] = '{1'b1,1'b1,32'h8,      1'b0,1'b0,1'b0,32'h0,        1'b0,32'h0000_0513,1'b0,32'h4,   1'b1};
    tbl[22] = '{1'b1,1'b0,32'h0,      1'b1,1'b0,1'b0,32'h0,        1'b0,32'h0000_0513,1'b0,32'h4,   1'b0};
    tbl[23] = '{1'b1,1'b0,32'h0,      1'b0,1'b0,1'b0,32'h0,        1'b0,32'h0000_0513,1'b0,32'h4,   1'b0};

    for (int i = 0; i < 24; i++) begin
      apply(tbl[i].rst, tbl[i].req, tbl[i].addr, tbl[i].flush,
            tbl[i].mb, tbl[i].de, tbl[i].din);
      check_all($sformatf("vec%0d", i), tbl[i].e_valid, tbl[i].e_inst,
                tbl[i].e_need, tbl[i].e_iaddr, tbl[i].e_busy);
    end

    // mem_busy holds off the fetch for five edges
    apply(1'b1, 1'b1, 32'h8, 1'b0, 1'b1, 1'b0, 32'h0);
    check_all("mb_miss", 1'b0, 32'h0000_0513, 1'b0, 32'h4, 1'b1);
    for (int i = 0; i < 5; i++) begin
      apply(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0);
      check_all($sformatf("mb_hold%0d", i), 1'b0, 32'h0000_0513, 1'b0, 32'h4, 1'b1);
    end
    apply(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    check_all("mb_issue", 1'b0, 32'h0000_0513, 1'b1, 32'h8, 1'b1);
    apply(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h1234_5678);
    check_all("mb_done", 1'b1, 32'h1234_5678, 1'b0, 32'h8, 1'b0);

    // flush two cycles into FILL: line still written, no delivery
    apply(1'b1, 1'b1, 32'h10, 1'b0, 1'b0, 1'b0, 32'h0);
    check_all("fl_miss", 1'b0, 32'h1234_5678, 1'b0, 32'h8, 1'b1);
    apply(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    check_all("fl_fill1", 1'b0, 32'h1234_5678, 1'b1, 32'h10, 1'b1);
    apply(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    check_all("fl_fill2", 1'b0, 32'h1234_5678, 1'b1, 32'h10, 1'b1);
    apply(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0);
    check_all("fl_drop", 1'b0, 32'h1234_5678, 1'b1, 32'h10, 1'b1);
    apply(1'b1, 1'b1, 32'h20, 1'b0, 1'b0, 1'b0, 32'h0);
    check_all("fl_ignore", 1'b0, 32'h1234_5678, 1'b1, 32'h10, 1'b1);
    apply(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'hCAFE_F00D);
    check_all("fl_done", 1'b0, 32'h1234_5678, 1'b0, 32'h10, 1'b0);
    apply(1'b1, 1'b1, 32'h10, 1'b0, 1'b0, 1'b0, 32'h0);
    check_all("fl_hit", 1'b1, 32'hCAFE_F00D, 1'b0, 32'h10, 1'b0);
    apply(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    check_all("fl_pulse", 1'b0, 32'hCAFE_F00D, 1'b0, 32'h10, 1'b0);

    // reset in the middle of a fill
    apply(1'b1, 1'b1, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    check_all("rs_hit", 1'b1, 32'h0000_0513, 1'b0, 32'h10, 1'b0);
    apply(1'b1, 1'b1, 32'h40, 1'b0, 1'b0, 1'b0, 32'h0);
    check_all("rs_miss", 1'b0, 32'h0000_0513, 1'b0, 32'h10, 1'b1);
    apply(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    check_all("rs_fill", 1'b0, 32'h0000_0513, 1'b1, 32'h40, 1'b1);
    apply(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    check_all("rs_reset", 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    apply(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'hDEAD_BEEF);
    check_all("rs_stray", 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    apply(1'b1, 1'b1, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    check_all("rs_remiss", 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    apply(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    check_all("rs_refill", 1'b0, 32'h0, 1'b1, 32'h0, 1'b1);
    apply(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h0000_0513);
    check_all("rs_done", 1'b1, 32'h0000_0513, 1'b0, 32'h0, 1'b0);

    // final report
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
